mem_bus_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two bus masters: master 0 (the CPU core) and master 1 (the debug/program loader).
- Sits between both masters and the memory.
- Each master uses a req/ack handshake. The arbiter serialises accesses, gives master 0 fixed priority, and guards master 1 against starvation with a burst limit.
- Read latency of the memory is a parameter.

---
 rtl/mem_bus_arbiter_if.sv | 15 +
 rtl/mem_bus_arbiter.sv | 97 +++++++++
 tb/tb_mem_bus_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - req/ack master port of the data-memory arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 8
);
  logic               req;
  logic               we;
  logic [ADDR_SZ-1:0] addr;
  logic [DATA_SZ-1:0] wdata;
  logic [DATA_SZ-1:0] rdata;
  logic               ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter for a single-port synchronous data memory
module mem_bus_arbiter #(
  parameter int ADDR_SZ   = 8,
  parameter int DATA_SZ   = 8,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   m0,
  mem_bus_arbiter_if.slave   m1,
  output logic [ADDR_SZ-1:0] mem_addr,
  output logic [DATA_SZ-1:0] mem_data_o,
  output logic               mem_we,
  input  logic [DATA_SZ-1:0] mem_data_i,
  output logic               owner,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT, ACK} state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
  localparam logic [2:0] LAT_LOAD    = 3'(RD_LAT);

  state_t             state;
  state_t             state_nxt;
  logic               we_q;
  logic [2:0]         wait_cnt;
  logic [3:0]         burst_cnt;
  logic               grant;
  logic               grant_m1;
  logic [DATA_SZ-1:0] m0_rdata_q;
  logic [DATA_SZ-1:0] m1_rdata_q;

  // Master 1 only wins a contested grant once master 0 has used up its burst.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_m1  = 1'b0;
    case (state)
      IDLE: begin
        if (m0.req || m1.req) begin
          grant     = 1'b1;
          grant_m1  = m1.req && (!m0.req || (burst_cnt == BURST_LIMIT));
          state_nxt = CMD;
        end
      end
      CMD:     state_nxt = we_q ? ACK : WAIT;
      WAIT:    if (wait_cnt == 3'd1) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_data_o <= '0;
      we_q       <= 1'b0;
      owner      <= 1'b0;
      burst_cnt  <= 4'd0;
      wait_cnt   <= 3'd0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (grant) begin
          owner      <= grant_m1;
          mem_addr   <= grant_m1 ? m1.addr  : m0.addr;
          mem_data_o <= grant_m1 ? m1.wdata : m0.wdata;
          we_q       <= grant_m1 ? m1.we    : m0.we;
        end
        if (!m1.req || grant_m1)
          burst_cnt <= 4'd0;
        else if (grant && burst_cnt != BURST_LIMIT)
          burst_cnt <= burst_cnt + 4'd1;
      end
      if (state == CMD && !we_q)
        wait_cnt <= LAT_LOAD;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) begin
          if (owner) m1_rdata_q <= mem_data_i;
          else       m0_rdata_q <= mem_data_i;
        end
      end
    end
  end

  assign mem_we   = (state == CMD) && we_q;
  assign busy     = (state != IDLE);
  assign m0.ack   = (state == ACK) && !owner;
  assign m1.ack   = (state == ACK) && owner;
  assign m0.rdata = m0_rdata_q;
  assign m1.rdata = m1_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench for mem_bus_arbiter at RD_LAT 1, 3 and 7
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_total = 0;
  int n_bad   = 0;

  logic [2:0] m0_req, m0_we, m1_req, m1_we, m0_ack, m1_ack;
  logic [2:0] mem_we, owner, busy, bd_we;
  logic [7:0] m0_addr [3];
  logic [7:0] m0_wdata[3];
  logic [7:0] m1_addr [3];
  logic [7:0] m1_wdata[3];
  logic [7:0] m0_rdata[3];
  logic [7:0] m1_rdata[3];
  logic [7:0] mem_addr[3];
  logic [7:0] mem_do  [3];
  logic [7:0] mem_di  [3];
  logic [7:0] bd_addr, bd_data;

  // Instance g runs with RD_LAT 1, 3, 7; each has its own memory model.
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 7);
    mem_bus_arbiter_if #(.ADDR_SZ(8), .DATA_SZ(8)) b0 ();
    mem_bus_arbiter_if #(.ADDR_SZ(8), .DATA_SZ(8)) b1 ();
    assign b0.req   = m0_req[g];
    assign b0.we    = m0_we[g];
    assign b0.addr  = m0_addr[g];
    assign b0.wdata = m0_wdata[g];
    assign b1.req   = m1_req[g];
    assign b1.we    = m1_we[g];
    assign b1.addr  = m1_addr[g];
    assign b1.wdata = m1_wdata[g];
    assign m0_ack[g]   = b0.ack;
    assign m1_ack[g]   = b1.ack;
    assign m0_rdata[g] = b0.rdata;
    assign m1_rdata[g] = b1.rdata;

    mem_bus_arbiter #(.ADDR_SZ(8), .DATA_SZ(8), .MAX_BURST(4), .RD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .m0(b0), .m1(b1),
      .mem_addr(mem_addr[g]), .mem_data_o(mem_do[g]), .mem_we(mem_we[g]),
      .mem_data_i(mem_di[g]), .owner(owner[g]), .busy(busy[g])
    );

    logic [7:0] mem  [256];
    logic [7:0] pipe [8];
    always @(posedge clk) begin
      if (bd_we[g]) mem[bd_addr] <= bd_data;
      else if (mem_we[g]) mem[mem_addr[g]] <= mem_do[g];
      pipe[0] <= mem[mem_addr[g]];
      for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_di[g] = pipe[LAT-1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bd_write(input int i, input logic [7:0] a, input logic [7:0] d);
    bd_addr   = a;
    bd_data   = d;
    bd_we[i]  = 1'b1;
    tick();
    bd_we[i]  = 1'b0;
  endtask

  int   seq[$];
  int   exp3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int   exp5[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
  logic flag;
  logic flag2;
  int   restore;

  initial begin
    rst = 1'b1;
    m0_req = '0; m0_we = '0; m1_req = '0; m1_we = '0; bd_we = '0;
    bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 3; i++) begin
      m0_addr[i] = '0; m0_wdata[i] = '0; m1_addr[i] = '0; m1_wdata[i] = '0;
    end
    tick(); tick();
    check("rst_mem_addr", mem_addr[0], 0);
    check("rst_mem_we",   mem_we[0], 0);
    check("rst_acks",     {m0_ack[0], m1_ack[0]}, 0);
    check("rst_owner",    owner[0], 0);
    check("rst_busy",     busy[0], 0);
    check("rst_rdata",    {m0_rdata[0], m1_rdata[0]}, 0);
    rst = 1'b0;
    tick();

    // m0 write 0x12 <- 0xA5
    check("wr_pre_we", mem_we[0], 0);
    m0_req[0] = 1'b1; m0_we[0] = 1'b1; m0_addr[0] = 8'h12; m0_wdata[0] = 8'hA5;
    tick();
    check("wr_t1_we",    mem_we[0], 1);
    check("wr_t1_addr",  mem_addr[0], 8'h12);
    check("wr_t1_data",  mem_do[0], 8'hA5);
    check("wr_t1_acks",  {m0_ack[0], m1_ack[0]}, 0);
    tick();
    check("wr_t2_we",    mem_we[0], 0);
    check("wr_t2_ack",   {m0_ack[0], m1_ack[0]}, 2'b10);
    m0_req[0] = 1'b0;
    tick();
    check("wr_t3_ack",   m0_ack[0], 0);
    check("wr_t3_busy",  busy[0], 0);

    // m1 read 0x40, memory holds 0x3C
    bd_write(0, 8'h40, 8'h3C);
    m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 8'h40;
    flag = 1'b0;
    tick(); flag |= mem_we[0];
    tick(); flag |= mem_we[0];
    check("rd_t2_ack", m1_ack[0], 0);
    tick(); flag |= mem_we[0];
    check("rd_t3_ack",   {m0_ack[0], m1_ack[0]}, 2'b01);
    check("rd_t3_rdata", m1_rdata[0], 8'h3C);
    check("rd_m0_rdata", m0_rdata[0], 8'h00);
    check("rd_no_we",    flag, 0);
    m1_req[0] = 1'b0;
    tick();
    check("rd_hold_rdata", m1_rdata[0], 8'h3C);
    check("rd_t4_ack",     m1_ack[0], 0);

    // both masters write continuously
    m0_we[0] = 1'b1; m0_addr[0] = 8'h01; m0_wdata[0] = 8'h11;
    m1_we[0] = 1'b1; m1_addr[0] = 8'h02; m1_wdata[0] = 8'h22;
    m0_req[0] = 1'b1; m1_req[0] = 1'b1;
    seq.delete(); flag = 1'b0;
    for (int c = 0; c < 80 && seq.size() < 10; c++) begin
      tick();
      if (m0_ack[0] && m1_ack[0]) flag = 1'b1;
      if (m0_ack[0]) seq.push_back(0);
      if (m1_ack[0]) seq.push_back(1);
    end
    m0_req[0] = 1'b0; m1_req[0] = 1'b0;
    check("burst_count", seq.size(), 10);
    check("burst_dbl_ack", flag, 0);
    for (int i = 0; i < seq.size() && i < 10; i++)
      check($sformatf("burst_seq%0d", i), seq[i], exp3[i]);
    tick();

    // m1 drops req for one IDLE cycle after two m0 grants
    m0_req[0] = 1'b1; m1_req[0] = 1'b1;
    seq.delete(); restore = -1;
    for (int c = 0; c < 80 && seq.size() < 8; c++) begin
      tick();
      if (c == restore) m1_req[0] = 1'b1;
      if (m0_ack[0]) seq.push_back(0);
      if (m1_ack[0]) seq.push_back(1);
      if (seq.size() == 2 && restore < 0 && m0_ack[0]) begin
        m1_req[0] = 1'b0;
        restore   = c + 2;
      end
    end
    m0_req[0] = 1'b0; m1_req[0] = 1'b0;
    check("clr_count", seq.size(), 8);
    for (int i = 0; i < seq.size() && i < 8; i++)
      check($sformatf("clr_seq%0d", i), seq[i], exp5[i]);
    tick();

    // reset during WAIT of an m0 read, RD_LAT=3
    bd_write(1, 8'h33, 8'h77);
    m0_req[1] = 1'b1; m0_we[1] = 1'b0; m0_addr[1] = 8'h33;
    tick(); tick();
    check("rst_wait_busy", busy[1], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; m0_req[1] = 1'b0;
    check("rst_mid_addr",  mem_addr[1], 0);
    check("rst_mid_we",    mem_we[1], 0);
    check("rst_mid_ack",   {m0_ack[1], m1_ack[1]}, 0);
    check("rst_mid_busy",  busy[1], 0);
    check("rst_mid_owner", owner[1], 0);
    check("rst_mid_rdata", m0_rdata[1], 0);
    flag = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      flag |= m0_ack[1];
    end
    check("rst_no_ack", flag, 0);
    m1_req[1] = 1'b1; m1_we[1] = 1'b1; m1_addr[1] = 8'h55; m1_wdata[1] = 8'h66;
    tick();
    check("post_t1_we",    mem_we[1], 1);
    check("post_t1_addr",  mem_addr[1], 8'h55);
    check("post_t1_owner", owner[1], 1);
    tick();
    check("post_t2_ack", {m0_ack[1], m1_ack[1]}, 2'b01);
    m1_req[1] = 1'b0;
    tick();

    // RD_LAT=7 read of 0xFF
    bd_write(2, 8'hFF, 8'hFF);
    check("lat7_pre_busy", busy[2], 0);
    m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_addr[2] = 8'hFF;
    flag = 1'b1; flag2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 9) flag &= busy[2];
      if (k < 9)  flag2 |= m0_ack[2];
      if (k == 9) begin
        check("lat7_ack",   m0_ack[2], 1);
        check("lat7_rdata", m0_rdata[2], 8'hFF);
        m0_req[2] = 1'b0;
      end
      if (k == 10) begin
        check("lat7_t10_busy", busy[2], 0);
        check("lat7_t10_ack",  m0_ack[2], 0);
      end
    end
    check("lat7_busy_span", flag, 1);
    check("lat7_early_ack", flag2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
